// File: rtl/fpu_dispatch_pkg.sv
// Shared types for the FPU op dispatcher: op encoding, unit tags, result flags.
package fpu_dispatch_pkg;

  localparam int unsigned TAG_W   = 2;
  localparam int unsigned FLAGS_W = 4;

  typedef enum logic [1:0] {
    OP_ADD  = 2'b00,
    OP_SUB  = 2'b01,
    OP_MUL  = 2'b10,
    OP_RSVD = 2'b11
  } fpu_op_e;

  typedef enum logic [TAG_W-1:0] {
    TAG_ADD  = 2'd0,
    TAG_MUL  = 2'd1,
    TAG_NULL = 2'd2
  } unit_tag_e;

  typedef struct packed {
    logic unimpl;
    logic invalid;
    logic ovf;
    logic unf;
  } fpu_flags_s;

endpackage

// File: rtl/fpu_tag_fifo.sv
// In-order unit-tag FIFO: depth_p entries, synchronous, no write-to-read bypass.
module fpu_tag_fifo
  import fpu_dispatch_pkg::*;
#(
  parameter int unsigned depth_p = 4
) (
  input  logic      clk_i,
  input  logic      reset_n_i,
  input  logic      push_i,
  input  unit_tag_e data_i,
  input  logic      pop_i,
  output unit_tag_e data_o,
  output logic      full_o,
  output logic      empty_o
);

  localparam int unsigned PTR_W = $clog2(depth_p);
  localparam int unsigned CNT_W = $clog2(depth_p + 1);

  unit_tag_e          mem_q [depth_p];
  logic [PTR_W-1:0]   wptr_q, wptr_d;
  logic [PTR_W-1:0]   rptr_q, rptr_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               do_push, do_pop;

  assign full_o  = (cnt_q == CNT_W'(depth_p));
  assign empty_o = (cnt_q == '0);
  assign data_o  = mem_q[rptr_q];

  // Pointers wrap naturally because depth_p is a power of two.
  always_comb begin : next_state
    do_push = push_i & ~full_o;
    do_pop  = pop_i & ~empty_o;
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    cnt_d   = cnt_q;
    if (do_push) wptr_d = wptr_q + PTR_W'(1);
    if (do_pop)  rptr_d = rptr_q + PTR_W'(1);
    if (do_push && !do_pop)      cnt_d = cnt_q + CNT_W'(1);
    else if (do_pop && !do_push) cnt_d = cnt_q - CNT_W'(1);
  end

  always_ff @(posedge clk_i) begin : state_reg
    if (!reset_n_i) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
    end
  end

  always_ff @(posedge clk_i) begin : storage
    if (do_push) mem_q[wptr_q] <= data_i;
  end

endmodule

// File: rtl/fpu_op_dispatch.sv
// Dispatches FP ops to add/sub and mul units and retires results in request order.
module fpu_op_dispatch
  import fpu_dispatch_pkg::*;
#(
  parameter int unsigned e_p     = 8,
  parameter int unsigned m_p     = 23,
  parameter int unsigned depth_p = 4
) (
  input  logic               clk_i,
  input  logic               reset_n_i,

  input  logic               v_i,
  output logic               ready_and_o,
  input  logic [1:0]         op_i,
  input  logic [e_p+m_p:0]   a_i,
  input  logic [e_p+m_p:0]   b_i,

  output logic               add_v_o,
  output logic [e_p+m_p:0]   add_a_o,
  output logic [e_p+m_p:0]   add_b_o,
  output logic               add_sub_o,
  input  logic               add_ready_and_i,
  input  logic               add_v_i,
  input  logic [e_p+m_p:0]   add_z_i,
  input  logic [3:0]         add_flags_i,
  output logic               add_yumi_o,

  output logic               mul_v_o,
  output logic [e_p+m_p:0]   mul_a_o,
  output logic [e_p+m_p:0]   mul_b_o,
  input  logic               mul_ready_and_i,
  input  logic               mul_v_i,
  input  logic [e_p+m_p:0]   mul_z_i,
  input  logic [3:0]         mul_flags_i,
  output logic               mul_yumi_o,

  output logic               v_o,
  output logic [e_p+m_p:0]   z_o,
  output logic               unimplemented_o,
  output logic               invalid_o,
  output logic               overflow_o,
  output logic               underflow_o,
  input  logic               yumi_i
);

  logic       is_add, is_mul, unit_rdy;
  logic       push, pop, head_rdy;
  logic       full, empty;
  unit_tag_e  push_tag, head_tag;
  fpu_flags_s flags;

  assign add_a_o   = a_i;
  assign add_b_o   = b_i;
  assign add_sub_o = op_i[0];
  assign mul_a_o   = a_i;
  assign mul_b_o   = b_i;

  // Request side: pick the target unit; reserved ops need no unit and are always ready.
  always_comb begin : dispatch
    is_add      = (op_i == OP_ADD) || (op_i == OP_SUB);
    is_mul      = (op_i == OP_MUL);
    push_tag    = TAG_NULL;
    unit_rdy    = 1'b1;
    if (is_add) begin
      push_tag = TAG_ADD;
      unit_rdy = add_ready_and_i;
    end else if (is_mul) begin
      push_tag = TAG_MUL;
      unit_rdy = mul_ready_and_i;
    end
    ready_and_o = reset_n_i & ~full & unit_rdy;
    add_v_o     = reset_n_i & v_i & is_add & ~full;
    mul_v_o     = reset_n_i & v_i & is_mul & ~full;
    push        = v_i & ready_and_o;
  end

  // Result side: only the unit named by the head tag may retire.
  always_comb begin : retire
    head_rdy = 1'b0;
    z_o      = '0;
    flags    = '0;
    if (reset_n_i && !empty) begin
      case (head_tag)
        TAG_ADD:  head_rdy = add_v_i;
        TAG_MUL:  head_rdy = mul_v_i;
        TAG_NULL: head_rdy = 1'b1;
        default:  head_rdy = 1'b0;
      endcase
    end
    if (head_rdy) begin
      case (head_tag)
        TAG_ADD: begin
          z_o   = add_z_i;
          flags = fpu_flags_s'(add_flags_i);
        end
        TAG_MUL: begin
          z_o   = mul_z_i;
          flags = fpu_flags_s'(mul_flags_i);
        end
        default: flags.unimpl = 1'b1;
      endcase
    end
    v_o        = head_rdy;
    pop        = head_rdy & yumi_i;
    add_yumi_o = pop & (head_tag == TAG_ADD);
    mul_yumi_o = pop & (head_tag == TAG_MUL);
  end

  assign {unimplemented_o, invalid_o, overflow_o, underflow_o} = flags;

  fpu_tag_fifo #(
    .depth_p (depth_p)
  ) u_tag_fifo (
    .clk_i     (clk_i),
    .reset_n_i (reset_n_i),
    .push_i    (push),
    .data_i    (push_tag),
    .pop_i     (pop),
    .data_o    (head_tag),
    .full_o    (full),
    .empty_o   (empty)
  );

endmodule

// File: doc/fpu_op_dispatch.md
FPU_OP_DISPATCH -- requirements
Module: fpu_op_dispatch

Interface
REQ-001 SHALL have parameter e_p, default 8, exponent width.
REQ-002 SHALL have parameter m_p, default 23, mantissa width; word width w = e_p+m_p+1.
REQ-003 SHALL have parameter depth_p, default 4, max outstanding ops; power of 2, >=2.
REQ-004 SHALL have one clock and a synchronous, active-low reset, with ports as below.
REQ-005 SHALL have ports:
- clk_i  in  1  clock.
- reset_n_i  in  1  synchronous, active-low reset.
- v_i  in  1  request valid.
- ready_and_o  out  1  request accepted when v_i&ready_and_o.
- op_i  in  2  op select: 00 add, 01 sub, 10 mul, 11 reserved.
- a_i, b_i  in  w  operands.
- add_v_o, add_a_o, add_b_o, add_sub_o  out  1/w/w/1  issue to add/sub unit.
- add_ready_and_i  in  1  add/sub unit ready.
- add_v_i, add_z_i, add_flags_i  in  1/w/4  add/sub result; flags {unimpl,invalid,ovf,unf}.
- add_yumi_o  out  1  pop add/sub result.
- mul_v_o, mul_a_o, mul_b_o, mul_ready_and_i, mul_v_i, mul_z_i, mul_flags_i, mul_yumi_o  same roles, multiplier.
- v_o  out  1  result valid.
- z_o  out  w  result.
- unimplemented_o, invalid_o, overflow_o, underflow_o  out  1  result flags.
- yumi_i  in  1  consumer takes result; legal only when v_o=1.

Function
REQ-006 SHALL route each request: ops 00/01 to the add/sub unit (add_sub_o=op_i[0]), 10 to mul, 11 to no unit (NULL).
REQ-007 SHALL drive add_v_o = v_i & op_i∈{00,01} & !full; mul_v_o = v_i & op_i==10 & !full; a_i/b_i forwarded unregistered.
REQ-008 SHALL drive ready_and_o = !full & (add_ready_and_i for add/sub | mul_ready_and_i for mul | 1 for reserved).
REQ-009 SHALL keep ready_and_o independent of yumi_i; push when full is blocked even if a pop occurs in the same cycle.
REQ-010 SHALL on each accepted request push the unit tag {ADD, MUL, NULL} into an in-order tag FIFO of depth_p entries.
REQ-011 SHALL assert v_o when FIFO non-empty and (head==NULL, or head==ADD & add_v_i, or head==MUL & mul_v_i).
REQ-012 SHALL present z_o/flags from the head unit; for NULL, z_o=0, unimplemented_o=1, other flags 0.
REQ-013 SHALL on yumi_i pop the FIFO and assert exactly the head unit's yumi (none for NULL) in the same cycle.
REQ-014 SHALL never assert add_yumi_o/mul_yumi_o when that unit is not at head; a ready result from the other unit waits.
REQ-015 SHALL return results in strict request order regardless of relative unit latency.
REQ-016 SHALL support simultaneous push and pop when neither full nor empty; count unchanged.
REQ-017 SHALL wrap read/write pointers modulo depth_p; count ranges 0..depth_p; full=(count==depth_p), empty=(count==0).

Reset
REQ-018 SHALL while reset_n_i=0 at a clock edge empty the FIFO; pointers and count to 0.
REQ-019 SHALL hold ready_and_o=0, v_o=0, all unit v/yumi outputs 0 while reset_n_i=0; z_o and flags 0 when v_o=0.
REQ-020 SHALL discard all outstanding tags on reset mid-operation; units SHALL be reset in the same cycle by the integrator.

Structure
REQ-021 SHALL place op encoding enum, unit tag enum (ADD=0, MUL=1, NULL=2) and the 4-bit flag struct in shared package fpu_dispatch_pkg.
REQ-022 SHALL implement tag storage as sub-module fpu_tag_fifo (depth_p x 2-bit, sync, no bypass).

Verification
REQ-023 SHALL cover: add 0x40400000+0x40000000 -> v_o with z_o=0x40A00000, flags 0.
REQ-024 SHALL cover: mul issued, then sub 0x40400000-0x40000000; sub result returns first -> v_o waits, outputs mul 0x40C00000 then 0x3F800000.
REQ-025 SHALL cover: depth_p=4 requests with yumi_i=0 -> ready_and_o=0 on 5th until one yumi_i, then accept next cycle.
REQ-026 SHALL cover: op_i=11 between two adds -> three results in order, middle z_o=0, unimplemented_o=1, no unit yumi.
REQ-027 SHALL cover: reset_n_i=0 with 3 outstanding -> next cycle v_o=0, count 0, ready_and_o=1 after release.
REQ-028 SHALL cover: add_ready_and_i=0 with add request valid -> ready_and_o=0, add_v_o=1, no FIFO push.
